// File: rtl/tpu_instr_sequencer_pkg.sv
// Shared field widths, opcode/state encodings and the instruction word layout
// for the TPU instruction sequencer.
package tpu_instr_sequencer_pkg;

  localparam int ADDR_W  = 12;
  localparam int DIM_W   = 9;
  localparam int INSTR_W = 3 + ADDR_W + 2 * DIM_W;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_LOAD_W = 3'd1,
    OP_MATMUL = 3'd2,
    OP_SYNC   = 3'd3,
    OP_HALT   = 3'd4
  } tpu_opcode_e;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] ub_addr;
    logic [DIM_W-1:0]  h_dim;
    logic [DIM_W-1:0]  w_dim;
  } tpu_instr_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HALTED = 3'd4,
    ST_ERR    = 3'd5
  } seq_state_e;

  // Opcodes above HALT are reserved encodings.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_HALT);
  endfunction

endpackage

// File: rtl/tpu_instr_sequencer_if.sv
// Host-side instruction stream, core issue/complete handshake and status bundle
// of the TPU instruction sequencer.
interface tpu_instr_sequencer_if #(
  parameter int IQ_DEPTH = 8,
  parameter int CNT_W    = 16
) ();
  import tpu_instr_sequencer_pkg::*;

  logic                      instr_valid;
  logic                      instr_ready;
  tpu_instr_t                instr;
  logic                      wfifo_valid;
  logic                      core_idle;
  logic                      core_done;
  logic                      core_start;
  logic [2:0]                core_op;
  logic [ADDR_W-1:0]         core_ub_addr;
  logic [DIM_W-1:0]          core_h_dim;
  logic [DIM_W-1:0]          core_w_dim;
  logic [$clog2(IQ_DEPTH):0] iq_count;
  logic                      busy;
  logic                      done;
  logic [CNT_W-1:0]          retired;
  logic                      halted;
  logic                      err;

  modport slave (
    input  instr_valid, instr, wfifo_valid, core_idle, core_done,
    output instr_ready, core_start, core_op, core_ub_addr, core_h_dim, core_w_dim,
           iq_count, busy, done, retired, halted, err
  );

  modport master (
    output instr_valid, instr, wfifo_valid, core_idle, core_done,
    input  instr_ready, core_start, core_op, core_ub_addr, core_h_dim, core_w_dim,
           iq_count, busy, done, retired, halted, err
  );

endinterface

// File: rtl/tpu_instr_sequencer_instr_queue.sv
// Synchronous instruction FIFO; power-of-two depth so pointers wrap naturally.
module tpu_instr_sequencer_instr_queue
  import tpu_instr_sequencer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  logic                   pop,
  input  tpu_instr_t             din,
  output tpu_instr_t             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  tpu_instr_t    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array, left unreset so it can map onto plain registers or RAM.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; reset empties the queue.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

endmodule

// File: rtl/tpu_instr_sequencer.sv
// TPU instruction front end: queues host instructions, decodes them in order,
// issues them to the core with a start/done handshake and retires them.
module tpu_instr_sequencer
  import tpu_instr_sequencer_pkg::*;
#(
  parameter int IQ_DEPTH = 8,
  parameter int CNT_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tpu_instr_sequencer_if.slave bus
);
  localparam int CW = $clog2(IQ_DEPTH) + 1;

  seq_state_e        state_r;
  seq_state_e        state_s;
  tpu_instr_t        exec_r;
  tpu_instr_t        head_s;
  logic [CW-1:0]     count_s;
  logic [CW-1:0]     count_next_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              retire_s;
  logic              ready_r;
  logic              busy_r;
  logic              start_r;
  logic              done_r;
  logic              halted_r;
  logic              err_r;
  logic [2:0]        op_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DIM_W-1:0]  h_dim_r;
  logic [DIM_W-1:0]  w_dim_r;
  logic [CNT_W-1:0]  retired_r;

  assign push_s       = bus.instr_valid & ready_r & ~full_s;
  assign count_next_s = count_s + CW'(push_s) - CW'(pop_s);

  tpu_instr_sequencer_instr_queue #(
    .DEPTH (IQ_DEPTH)
  ) u_queue (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push_s),
    .pop   (pop_s),
    .din   (bus.instr),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Next-state, pop and retire decisions.
  always_comb begin
    state_s  = state_r;
    pop_s    = 1'b0;
    retire_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_s = ST_DECODE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (!is_legal_op(exec_r.opcode)) begin
          state_s = ST_ERR;
        end else begin
          case (exec_r.opcode)
            OP_NOP: begin
              retire_s = 1'b1;
              state_s  = ST_IDLE;
            end
            OP_LOAD_W: begin
              if (bus.wfifo_valid) begin
                state_s = ST_ISSUE;
              end else begin
                state_s = ST_DECODE;
              end
            end
            OP_MATMUL: begin
              if ((exec_r.h_dim == {DIM_W{1'b0}}) || (exec_r.w_dim == {DIM_W{1'b0}})) begin
                state_s = ST_ERR;
              end else begin
                state_s = ST_ISSUE;
              end
            end
            OP_SYNC: begin
              if (bus.core_idle) begin
                retire_s = 1'b1;
                state_s  = ST_IDLE;
              end else begin
                state_s = ST_DECODE;
              end
            end
            OP_HALT: begin
              retire_s = 1'b1;
              state_s  = ST_HALTED;
            end
            default: state_s = ST_ERR;
          endcase
        end
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (bus.core_done) begin
          retire_s = 1'b1;
          state_s  = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HALTED: state_s = ST_HALTED;
      ST_ERR:    state_s = ST_ERR;
      default:   state_s = ST_ERR;
    endcase
  end

  // State, exec register and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r   <= ST_IDLE;
      exec_r    <= '{opcode: 3'd0, ub_addr: {ADDR_W{1'b0}}, h_dim: {DIM_W{1'b0}}, w_dim: {DIM_W{1'b0}}};
      ready_r   <= 1'b0;
      busy_r    <= 1'b0;
      start_r   <= 1'b0;
      done_r    <= 1'b0;
      halted_r  <= 1'b0;
      err_r     <= 1'b0;
      op_r      <= 3'd0;
      addr_r    <= {ADDR_W{1'b0}};
      h_dim_r   <= {DIM_W{1'b0}};
      w_dim_r   <= {DIM_W{1'b0}};
      retired_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (pop_s) begin
        exec_r <= head_s;
      end
      start_r <= (state_s == ST_ISSUE);
      // Core fields latch on the way into ISSUE and hold until the next issue.
      if (state_s == ST_ISSUE) begin
        op_r    <= exec_r.opcode;
        addr_r  <= exec_r.ub_addr;
        h_dim_r <= exec_r.h_dim;
        w_dim_r <= exec_r.w_dim;
      end
      done_r <= retire_s;
      if (retire_s) begin
        retired_r <= retired_r + CNT_W'(1);
      end
      halted_r <= halted_r | (state_s == ST_HALTED);
      err_r    <= err_r | (state_s == ST_ERR);
      ready_r  <= (count_next_s < CW'(IQ_DEPTH)) && (state_s != ST_HALTED) && (state_s != ST_ERR);
      busy_r   <= (state_s != ST_IDLE) || (count_next_s != {CW{1'b0}});
    end
  end

  assign bus.instr_ready  = ready_r;
  assign bus.core_start   = start_r;
  assign bus.core_op      = op_r;
  assign bus.core_ub_addr = addr_r;
  assign bus.core_h_dim   = h_dim_r;
  assign bus.core_w_dim   = w_dim_r;
  assign bus.iq_count     = count_s;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.retired      = retired_r;
  assign bus.halted       = halted_r;
  assign bus.err          = err_r;

endmodule
